// File: rtl/bus_mailbox_slave.sv
// bus_mailbox_slave
//   Bridge-bus slave with two independent FIFOs that give the host a
//   streaming channel into user logic:
//     H2F (host-to-fabric): bus writes to offset 0 push, fabric pops.
//     F2H (fabric-to-host): fabric pushes, bus reads of offset 0 pop.
//   Offset 1 reads STATUS and writes CTRL. Offsets 2-3 are unmapped.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_addr/i_we/i_data  bus word address, write strobe, write data
//   i_re                bus read strobe
//   o_data/o_ack        registered read data and 1-cycle read acknowledge
//   o_rdata/o_rvalid    H2F head word (fall-through) and not-empty
//   i_rready            fabric pops H2F when o_rvalid & i_rready
//   i_wdata/i_wvalid    F2H fabric push data and strobe
//   o_wready            F2H not full
module bus_mailbox_slave #(
  parameter logic [31:0] ADDRVAL    = 32'hE0000000,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [31:0] i_data,
  input  logic        i_re,
  output logic [31:0] o_data,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  input  logic        i_rready,
  input  logic [31:0] i_wdata,
  input  logic        i_wvalid,
  output logic        o_wready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [31:0] h2f_mem [DEPTH];
  logic [31:0] f2h_mem [DEPTH];

  logic [PW-1:0] h2f_wptr_q, h2f_wptr_d, h2f_rptr_q, h2f_rptr_d;
  logic [PW-1:0] f2h_wptr_q, f2h_wptr_d, f2h_rptr_q, f2h_rptr_d;
  logic          h2f_ovf_q, h2f_ovf_d, f2h_unf_q, f2h_unf_d;
  logic          ack_q, ack_d;
  logic [31:0]   data_q, data_d;

  logic        sel, h2f_push_req, ctrl_wr, f2h_pop_req, stat_rd;
  logic        h2f_full, h2f_empty, f2h_full, f2h_empty;
  logic        flush_h2f, flush_f2h, clr_flags;
  logic        h2f_push, h2f_pop, f2h_push, f2h_pop;
  logic        ovf_evt, unf_evt;
  logic [31:0] status;

  // Full: wrap bits differ and the index bits match.
  function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
  endfunction

  function automatic logic [7:0] ptr_level(input logic [PW-1:0] w, input logic [PW-1:0] r);
    logic [PW-1:0] diff;
    diff = w - r;
    return 8'(diff);
  endfunction

  always_comb begin
    sel          = (i_addr & ~32'h3) == ADDRVAL;
    h2f_push_req = i_we & sel & (i_addr[1:0] == 2'd0);
    ctrl_wr      = i_we & sel & (i_addr[1:0] == 2'd1);
    f2h_pop_req  = i_re & sel & (i_addr[1:0] == 2'd0);
    stat_rd      = i_re & sel & (i_addr[1:0] == 2'd1);

    h2f_full  = ptr_full(h2f_wptr_q, h2f_rptr_q);
    h2f_empty = (h2f_wptr_q == h2f_rptr_q);
    f2h_full  = ptr_full(f2h_wptr_q, f2h_rptr_q);
    f2h_empty = (f2h_wptr_q == f2h_rptr_q);

    flush_h2f = ctrl_wr & i_data[0];
    flush_f2h = ctrl_wr & i_data[1];
    clr_flags = ctrl_wr & i_data[2];

    // Fullness/emptiness come from pre-edge state: a same-cycle pop never
    // rescues a push to a full FIFO, and a push never feeds a pop on empty.
    // A flush swallows a same-cycle push without raising overflow.
    h2f_push = h2f_push_req & ~h2f_full & ~flush_h2f;
    ovf_evt  = h2f_push_req &  h2f_full & ~flush_h2f;
    h2f_pop  = ~h2f_empty & i_rready;
    f2h_push = i_wvalid & ~f2h_full & ~flush_f2h;
    f2h_pop  = f2h_pop_req & ~f2h_empty;
    unf_evt  = f2h_pop_req &  f2h_empty;

    h2f_wptr_d = h2f_wptr_q + PW'(h2f_push);
    h2f_rptr_d = h2f_rptr_q + PW'(h2f_pop);
    if (flush_h2f) begin
      h2f_wptr_d = '0;
      h2f_rptr_d = '0;
    end
    f2h_wptr_d = f2h_wptr_q + PW'(f2h_push);
    f2h_rptr_d = f2h_rptr_q + PW'(f2h_pop);
    if (flush_f2h) begin
      f2h_wptr_d = '0;
      f2h_rptr_d = '0;
    end

    // A new error event beats a same-cycle clear.
    h2f_ovf_d = ovf_evt | (h2f_ovf_q & ~clr_flags);
    f2h_unf_d = unf_evt | (f2h_unf_q & ~clr_flags);

    status        = '0;
    status[7:0]   = ptr_level(h2f_wptr_q, h2f_rptr_q);
    status[15:8]  = ptr_level(f2h_wptr_q, f2h_rptr_q);
    status[16]    = h2f_full;
    status[17]    = f2h_empty;
    status[24]    = h2f_ovf_q;
    status[25]    = f2h_unf_q;

    // o_data is zero whenever no ack is presented.
    ack_d  = f2h_pop_req | stat_rd;
    data_d = '0;
    if (f2h_pop)
      data_d = f2h_mem[f2h_rptr_q[PW-2:0]];
    else if (stat_rd)
      data_d = status;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h2f_wptr_q <= '0;
      h2f_rptr_q <= '0;
      f2h_wptr_q <= '0;
      f2h_rptr_q <= '0;
      h2f_ovf_q  <= 1'b0;
      f2h_unf_q  <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      h2f_wptr_q <= h2f_wptr_d;
      h2f_rptr_q <= h2f_rptr_d;
      f2h_wptr_q <= f2h_wptr_d;
      f2h_rptr_q <= f2h_rptr_d;
      h2f_ovf_q  <= h2f_ovf_d;
      f2h_unf_q  <= f2h_unf_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
    end
  end

  // Storage carries no reset; the pointers alone define contents.
  always_ff @(posedge i_clk) begin
    if (h2f_push) h2f_mem[h2f_wptr_q[PW-2:0]] <= i_data;
    if (f2h_push) f2h_mem[f2h_wptr_q[PW-2:0]] <= i_wdata;
  end

  assign o_ack    = ack_q;
  assign o_data   = data_q;
  assign o_rdata  = h2f_mem[h2f_rptr_q[PW-2:0]];
  assign o_rvalid = ~h2f_empty;
  assign o_wready = ~f2h_full;

endmodule
